// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the halt opcode, fetch FSM states
// and the IF/ID bubble constant used by the pipeline registers.
package cpu_pkg;

   localparam int PC_W    = 12;
   localparam int INSTR_W = 16;

   localparam logic [3:0]         OPC_HLT  = 4'hF;
   localparam logic [PC_W-1:0]    RESET_PC = '0;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // 16'h0000 is a legal opcode, so a bubble is identified only by valid=0.
   localparam logic [INSTR_W-1:0] BUBBLE_INSTR = '0;
   localparam logic               BUBBLE_VALID = 1'b0;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4] == OPC_HLT;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Inter-stage pipeline register with hold (stall) and flush (bubble insert).
// Flush takes priority over hold so a redirect always kills the wrong path.
module ifid_reg
   import cpu_pkg::*;
#(
   parameter int DW = INSTR_W,
   parameter int AW = PC_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold_i,
   input  logic          flush_i,
   input  logic [DW-1:0] instr_i,
   input  logic [AW-1:0] pc_i,
   input  logic          valid_i,
   output logic [DW-1:0] instr_o,
   output logic [AW-1:0] pc_o,
   output logic          valid_o
);

   logic [DW-1:0] instr_q;
   logic [AW-1:0] pc_q;
   logic          valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         instr_q <= DW'(BUBBLE_INSTR);
         valid_q <= BUBBLE_VALID;
      end else if (!hold_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= valid_i;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: program counter, next-PC selection and the
// BOOT/RUN/HALTED control FSM, feeding the IF/ID pipeline register.
module pc_fetch_stage
   import cpu_pkg::*;
#(
   parameter int               PC_W     = cpu_pkg::PC_W,
   parameter int               INSTR_W  = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0]  RESET_PC = cpu_pkg::RESET_PC,
   parameter logic [3:0]       OPC_HLT  = cpu_pkg::OPC_HLT
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    PCAdd_pc,
   input  logic [INSTR_W-1:0] M_instruction,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               halted
);

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              ifid_hold, ifid_flush;
   logic              fetch_is_halt;

   assign fetch_is_halt = M_instruction[INSTR_W-1 -: 4] == OPC_HLT;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Redirect outranks stall in both RUN and HALTED; a halt word only counts
   // when it is actually advanced into IF/ID.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_hold  = 1'b1;
      ifid_flush = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               pc_d       = branch_target;
               ifid_flush = 1'b1;
            end else if (!stall) begin
               ifid_hold = 1'b0;
               if (fetch_is_halt) state_d = HALTED;
               else               pc_d    = pc_q + 1'b1;
            end
         end
         HALTED: begin
            if (branch_taken) begin
               pc_d       = branch_target;
               ifid_flush = 1'b1;
               state_d    = RUN;
            end else if (!stall) begin
               ifid_flush = 1'b1;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   ifid_reg #(
      .DW (INSTR_W),
      .AW (PC_W)
   ) u_ifid (
      .clk     (clk),
      .rst     (reset),
      .hold_i  (ifid_hold),
      .flush_i (ifid_flush),
      .instr_i (M_instruction),
      .pc_i    (pc_q),
      .valid_i (1'b1),
      .instr_o (ifid_instr),
      .pc_o    (ifid_pc),
      .valid_o (ifid_valid)
   );

   assign PCAdd_pc = pc_q;
   assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: a behavioural fetch model predicts each
// instruction decode should receive; a monitor checks what decode accepts.
module tb_pc_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] PCAdd_pc;
   logic [15:0] M_instruction;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [11:0] branch_target = '0;
   logic [15:0] ifid_instr;
   logic [11:0] ifid_pc;
   logic        ifid_valid;
   logic        halted;

   logic [15:0] mem [4096];
   assign M_instruction = mem[PCAdd_pc];

   pc_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .PCAdd_pc      (PCAdd_pc),
      .M_instruction (M_instruction),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_valid    (ifid_valid),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] instr;
      logic [11:0] pc;
   } item_t;
   item_t exp_q[$];
   item_t mon_e;

   // Abstract fetch model: where fetch points, whether decode holds a live
   // instruction, and whether we are booting, running or frozen.
   typedef enum {M_BOOT, M_RUN, M_HALT} mmode_e;
   mmode_e      m_mode;
   logic [11:0] m_pc;
   logic        m_ifv;
   logic [11:0] halt_addr [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge: check current state, apply inputs for the next
   // rising edge, advance the model, then wait one full cycle.
   task automatic step(input logic br, input logic st, input logic [11:0] tgt);
      check("PCAdd_pc", 32'(PCAdd_pc), 32'(m_pc));
      check("halted", 32'(halted), 32'(m_mode == M_HALT));
      check("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
      branch_taken  = br;
      stall         = st;
      branch_target = tgt;
      if (m_mode == M_BOOT) begin
         m_mode = M_RUN;
      end else if (br) begin
         if (m_ifv && st && exp_q.size() > 0) void'(exp_q.pop_front());
         m_pc   = tgt;
         m_ifv  = 1'b0;
         m_mode = M_RUN;
      end else if (!st) begin
         if (m_mode == M_HALT) begin
            m_ifv = 1'b0;
         end else begin
            exp_q.push_back({mem[m_pc], m_pc});
            m_ifv = 1'b1;
            if (mem[m_pc][15:12] == 4'hF) m_mode = M_HALT;
            else                          m_pc   = m_pc + 12'd1;
         end
      end
      @(negedge clk);
   endtask

   // Decode accepts IF/ID on a rising edge where it is valid and not stalled.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset && ifid_valid && !stall) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid actual=%0h@%0h required=none", ifid_instr, ifid_pc);
            end else begin
               mon_e = exp_q.pop_front();
               check("ifid_instr", 32'(ifid_instr), 32'(mon_e.instr));
               check("ifid_pc", 32'(ifid_pc), 32'(mon_e.pc));
            end
         end
      end
   end

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 4096; i++) begin
         w = $urandom;
         if (w[15:12] == 4'hF) w[15:12] = 4'h1;
         mem[i] = w[15:0];
      end
      mem[0] = 16'h0000;
      mem[1] = 16'h8021;
      mem[2] = 16'h8132;
      mem[3] = 16'h8213;
      mem[4] = 16'hF000;
      m_mode = M_BOOT;
      m_pc   = 12'h000;
      m_ifv  = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_pc", 32'(PCAdd_pc), 32'h000);
      check("rst_ifid_instr", 32'(ifid_instr), 32'h0000);
      check("rst_ifid_pc", 32'(ifid_pc), 32'h000);
      check("rst_ifid_valid", 32'(ifid_valid), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      reset = 1'b0;

      // Boot bubble, straight-line fetch, 3-cycle stall with ifid_pc=1.
      step(1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b0, 12'h000);
      repeat (3) step(1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b0, 12'h000);
      // Redirect together with stall: redirect wins.
      step(1'b1, 1'b1, 12'h100);
      repeat (3) step(1'b0, 1'b0, 12'h000);
      // Wrap across the top of the address space.
      step(1'b1, 1'b0, 12'hFFE);
      repeat (5) step(1'b0, 1'b0, 12'h000);
      // Run into the halt at 4, stay frozen, then leave via redirect to 2.
      step(1'b1, 1'b0, 12'h000);
      repeat (5) step(1'b0, 1'b0, 12'h000);
      repeat (12) step(1'b0, 1'($urandom_range(0, 1)), 12'h000);
      step(1'b1, 1'($urandom_range(0, 1)), 12'h002);
      repeat (3) step(1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b1, 12'h000);

      // Asynchronous reset mid-cycle while HALTED with a redirect pending.
      check("pre_rst_halted", 32'(halted), 32'h1);
      check("pre_rst_instr", 32'(ifid_instr), 32'hF000);
      branch_taken  = 1'b1;
      branch_target = 12'h0AB;
      stall         = 1'b1;
      #3 reset = 1'b1;
      #1;
      check("async_pc", 32'(PCAdd_pc), 32'h000);
      check("async_ifid_valid", 32'(ifid_valid), 32'h0);
      check("async_ifid_instr", 32'(ifid_instr), 32'h0000);
      check("async_halted", 32'(halted), 32'h0);
      exp_q.delete();
      m_mode = M_BOOT;
      m_pc   = 12'h000;
      m_ifv  = 1'b0;
      @(negedge clk);
      reset         = 1'b0;
      branch_taken  = 1'b0;
      stall         = 1'b0;
      step(1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b0, 12'h000);

      // Randomised traffic with extra halt words scattered through memory.
      for (int i = 0; i < 8; i++) begin
         halt_addr[i] = 12'(16 + $urandom_range(0, 4079));
         mem[halt_addr[i]] = {4'hF, 12'($urandom)};
      end
      for (int i = 0; i < 400; i++) begin
         logic        br, st;
         logic [11:0] tgt;
         br  = ($urandom_range(0, 9) == 0);
         st  = ($urandom_range(0, 3) == 0);
         tgt = ($urandom_range(0, 2) == 0) ? halt_addr[$urandom_range(0, 7)] : 12'($urandom);
         step(br, st, tgt);
      end

      // Finish parked on the halt at 4 so every prediction has been delivered.
      step(1'b1, 1'b0, 12'h004);
      repeat (3) step(1'b0, 1'b0, 12'h000);
      #3;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch front end: owns the 12-bit program counter and drives the address into the instruction memory.
- Registers the returned 16-bit instruction into the IF/ID pipeline register for the decoder.
- Handles decode stalls, branch redirects with flush, and a halt opcode that freezes fetch.
- Sits between the execute-stage branch logic and the decode stage.

Parameters:
- PC_W, 12, program counter / instruction address width (4096-entry memory).
- INSTR_W, 16, instruction width.
- RESET_PC, 12'h000, PC value loaded on reset.
- OPC_HLT, 4'hF, value of instr[15:12] that halts fetch.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- PCAdd_pc  output  PC_W  fetch address to instruction memory; equals the PC register (combinational, no extra logic).
- M_instruction  input  INSTR_W  instruction read combinationally from memory at PCAdd_pc.
- stall  input  1  decode cannot accept; hold PC and IF/ID.
- branch_taken  input  1  redirect request from execute.
- branch_target  input  PC_W  redirect address.
- ifid_instr  output  INSTR_W  registered instruction to decode.
- ifid_pc  output  PC_W  address of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real instruction; 0 means bubble.
- halted  output  1  fetch frozen by halt opcode.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: PC=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, state=BOOT, halted=0.
- Reset asserted mid-operation aborts everything immediately, including a pending redirect or halt.
- State machine has three states: BOOT, RUN, HALTED.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - PC holds, ifid_valid stays 0, then go to RUN.
  - Inputs are ignored.
- RUN, priority order is branch_taken > stall > normal:
  - branch_taken=1: PC<=branch_target, ifid_instr<=0, ifid_valid<=0. This flushes the wrong-path fetch and overrides stall.
  - stall=1 (no branch): PC, ifid_instr, ifid_pc and ifid_valid all hold.
  - normal: ifid_instr<=M_instruction, ifid_pc<=PC, ifid_valid<=1, PC<=PC+1.
  - PC increment is modulo 2^PC_W; 12'hFFF wraps to 12'h000 with no flag.
  - Halt on normal advance: if M_instruction[15:12]==OPC_HLT, the halt instruction is still latched into IF/ID with valid=1. PC holds at the halt address, and the state goes to HALTED.
  - A halt opcode seen during a stall or redirect cycle has no effect.
- HALTED:
  - halted=1. PC holds and no new fetch occurs.
  - ifid_valid<=0 on the first non-stalled cycle, so the halt instruction is delivered to decode exactly once. While stall=1 the IF/ID register holds.
  - branch_taken=1 (an older branch resolving) redirects PC, flushes IF/ID and returns to RUN. This takes priority over stall.
  - Only reset or a redirect leaves HALTED.
- Latency:
  - Instruction at address A appears on ifid_instr at the first rising edge after PCAdd_pc==A with stall=0.
  - A redirect issued in cycle N makes PCAdd_pc=target in cycle N+1, and the target instruction is valid in IF/ID in cycle N+2.
- Simultaneous stall and branch_taken: the redirect wins and the bubble is inserted.
- branch_target is not range-checked; any 12-bit value is legal.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W and INSTR_W.
  - OPC_HLT.
  - The fetch state enum (BOOT, RUN, HALTED).
  - A bubble constant: instr=16'h0000, valid=0. 16'h0000 is a legal opcode, so validity is carried only by ifid_valid.
- One natural sub-module: ifid_reg.
  - Contents: the IF/ID register with hold (stall) and clear (flush) controls.
  - It is reused later for ID/EX and EX/MEM.
- PC register, next-PC mux and the FSM stay in pc_fetch_stage.

Test Plan:
- Reset then run with memory [0]=16'h0000, [1]=16'h8021, [2]=16'h8132, [3]=16'h8213, stall=0 -> one BOOT bubble, then ifid_instr 0000/8021/8132/8213 with ifid_pc 0,1,2,3 and valid=1 on consecutive cycles.
- stall=1 for 3 cycles while ifid_pc=1 -> PCAdd_pc stays 2 and ifid_instr stays 16'h8021 throughout; on release the next valid word is 16'h8132, with no duplicate and no skip.
- branch_taken=1, target=12'h100, asserted together with stall=1 -> next cycle ifid_valid=0 and PCAdd_pc=12'h100; following cycle ifid_pc=12'h100, valid=1.
- PC forced near top via redirect to 12'hFFE with linear code -> ifid_pc sequence FFE, FFF, 000, 001; wrap gives no gap.
- [4]=16'hF000 -> ifid_instr=16'hF000 valid for exactly one cycle, halted=1, PCAdd_pc frozen at 4 for 10+ cycles; then branch_taken to 12'h002 -> halted=0 and fetch resumes at 2.
- Assert reset asynchronously mid-cycle during HALTED with branch_taken=1 -> outputs clear immediately without waiting for a clock edge, PC=0, and BOOT is re-entered.
